// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle control sequencer:
//   - RV32I opcode / funct3 / funct7 constants for the supported subset
//   - alu_op_t     : 3-bit ALU operation code driven on ALUctrl
//   - ctrl_state_t : sequencer state (FETCH, DECODE, EXECUTE, WRITEBACK, TRAP)
// No ports (package).
// -----------------------------------------------------------------------------
package ctrl_pkg;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // funct3 values (instr[14:12])
   localparam logic [2:0] F3_ADD = 3'b000;   // ADDI, ADD, SUB
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   // funct7 values (instr[31:25])
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011
   } alu_op_t;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_WRITEBACK = 3'd3,
      ST_TRAP      = 3'd4
   } ctrl_state_t;

endpackage

// File: rtl/multicycle_ctrl_instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
// Purely combinational decoder for the supported RV32I subset
// (ADDI, ADD, SUB, AND, OR, BEQ, BNE). Everything else is flagged illegal.
// Ports:
//   word      in  32        instruction word (normally the instruction register)
//   rs1, rs2  out A_WIDTH   source register fields
//   rd        out A_WIDTH   destination register field
//   alu_ctrl  out 3         ALU operation (alu_op_t encoding)
//   alu_src   out 1         0 = register operand, 1 = immediate
//   imm_src   out 1         0 = I-type immediate, 1 = B-type immediate
//   is_branch out 1         word is BEQ or BNE
//   is_beq    out 1         word is BEQ (only meaningful with is_branch)
//   illegal   out 1         word is outside the supported subset
// -----------------------------------------------------------------------------
module instr_decode
   import ctrl_pkg::*;
#(
   parameter int A_WIDTH = 5
) (
   input  logic [31:0]        word,
   output logic [A_WIDTH-1:0] rs1,
   output logic [A_WIDTH-1:0] rs2,
   output logic [A_WIDTH-1:0] rd,
   output logic [2:0]         alu_ctrl,
   output logic               alu_src,
   output logic               imm_src,
   output logic               is_branch,
   output logic               is_beq,
   output logic               illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   alu_op_t    alu_op;

   assign opcode = word[6:0];
   assign funct3 = word[14:12];
   assign funct7 = word[31:25];

   // RV32I register fields are 5 bits; resize to the configured address width.
   assign rs1 = A_WIDTH'(word[19:15]);
   assign rs2 = A_WIDTH'(word[24:20]);
   assign rd  = A_WIDTH'(word[11:7]);

   always_comb begin
      alu_op    = ALU_ADD;
      alu_src   = 1'b0;
      imm_src   = 1'b0;
      is_branch = 1'b0;
      is_beq    = 1'b0;
      illegal   = 1'b1;
      case (opcode)
         OP_IMM: begin
            if (funct3 == F3_ADD) begin
               illegal = 1'b0;
               alu_src = 1'b1;
            end
         end
         OP_REG: begin
            if (funct7 == F7_BASE) begin
               case (funct3)
                  F3_ADD: begin illegal = 1'b0; alu_op = ALU_ADD; end
                  F3_AND: begin illegal = 1'b0; alu_op = ALU_AND; end
                  F3_OR:  begin illegal = 1'b0; alu_op = ALU_OR;  end
                  default: ;
               endcase
            end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
               illegal = 1'b0;
               alu_op  = ALU_SUB;
            end
         end
         OP_BRANCH: begin
            // Branch compare is done by subtracting and watching EQ.
            if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
               illegal   = 1'b0;
               is_branch = 1'b1;
               is_beq    = (funct3 == F3_BEQ);
               alu_op    = ALU_SUB;
               imm_src   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign alu_ctrl = alu_op;

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle control sequencer for the register-file / ALU datapath.
// Accepts one instruction per valid/ready handshake and steps the datapath
// through DECODE, EXECUTE and (for ALU ops) WRITEBACK, driving the PC update.
//
// Handshake: an instruction is transferred on a rising edge where
// instr_valid && instr_ready are both 1. instr_ready is 1 only in FETCH (and
// never while rst is high); instr_valid in any other state is ignored and the
// offered word stays with the producer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instr_valid/ready   instruction handshake, instr = RV32I word
//   EQ                  ALU equal flag, sampled in EXECUTE of a branch
//   rs1, rs2, rd        register-file addresses from the latched word
//   RegWrite            register write enable (WRITEBACK, rd != 0)
//   ALUsrc, ALUctrl,
//   ImmSrc              datapath controls (EXECUTE and WRITEBACK)
//   pc_en, pc_sel       one-cycle PC update strobe and PC+4 / PC+imm select
//   trap                sticky illegal-instruction flag
//   retired             wrapping count of completed instructions
// -----------------------------------------------------------------------------
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int A_WIDTH = 5,
   parameter int D_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [D_WIDTH-1:0] instr,
   input  logic               EQ,
   output logic [A_WIDTH-1:0] rs1,
   output logic [A_WIDTH-1:0] rs2,
   output logic [A_WIDTH-1:0] rd,
   output logic               RegWrite,
   output logic               ALUsrc,
   output logic [2:0]         ALUctrl,
   output logic               ImmSrc,
   output logic               pc_en,
   output logic               pc_sel,
   output logic               trap,
   output logic [D_WIDTH-1:0] retired
);

   ctrl_state_t        state;
   logic [D_WIDTH-1:0] ir;
   logic [D_WIDTH-1:0] retired_q;

   logic [A_WIDTH-1:0] dec_rs1;
   logic [A_WIDTH-1:0] dec_rs2;
   logic [A_WIDTH-1:0] dec_rd;
   logic [2:0]         dec_alu_ctrl;
   logic               dec_alu_src;
   logic               dec_imm_src;
   logic               dec_is_branch;
   logic               dec_is_beq;
   logic               dec_illegal;

   // The decoder only ever sees the instruction register, so no output has a
   // path from instr / instr_valid.
   instr_decode #(
      .A_WIDTH (A_WIDTH)
   ) u_decode (
      .word      (ir[31:0]),
      .rs1       (dec_rs1),
      .rs2       (dec_rs2),
      .rd        (dec_rd),
      .alu_ctrl  (dec_alu_ctrl),
      .alu_src   (dec_alu_src),
      .imm_src   (dec_imm_src),
      .is_branch (dec_is_branch),
      .is_beq    (dec_is_beq),
      .illegal   (dec_illegal)
   );

   // Sequencer: state, instruction register and retired counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_FETCH;
         ir        <= '0;
         retired_q <= '0;
      end else begin
         unique case (state)
            ST_FETCH: begin
               if (instr_valid) begin
                  ir    <= instr;
                  state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               state <= dec_illegal ? ST_TRAP : ST_EXECUTE;
            end
            ST_EXECUTE: begin
               if (dec_is_branch) begin
                  retired_q <= retired_q + D_WIDTH'(1);
                  state     <= ST_FETCH;
               end else begin
                  state <= ST_WRITEBACK;
               end
            end
            ST_WRITEBACK: begin
               retired_q <= retired_q + D_WIDTH'(1);
               state     <= ST_FETCH;
            end
            ST_TRAP: begin
               state <= ST_TRAP;
            end
            default: begin
               state <= ST_FETCH;
            end
         endcase
      end
   end

   // Outputs are decoded from the registered state and instruction register.
   // They are not a further register stage because the branch decision must
   // use EQ in the same EXECUTE cycle, and because every output must read 0
   // while rst is held, including the cycle before the first reset edge.
   always_comb begin
      instr_ready = 1'b0;
      rs1         = '0;
      rs2         = '0;
      rd          = '0;
      RegWrite    = 1'b0;
      ALUsrc      = 1'b0;
      ALUctrl     = 3'b000;
      ImmSrc      = 1'b0;
      pc_en       = 1'b0;
      pc_sel      = 1'b0;
      trap        = 1'b0;
      retired     = '0;
      if (!rst) begin
         // Register fields follow the instruction register, so they hold
         // until the next accepted word.
         rs1     = dec_rs1;
         rs2     = dec_rs2;
         rd      = dec_rd;
         retired = retired_q;
         unique case (state)
            ST_FETCH: begin
               instr_ready = 1'b1;
            end
            ST_DECODE: ;
            ST_EXECUTE: begin
               ALUctrl = dec_alu_ctrl;
               ALUsrc  = dec_alu_src;
               ImmSrc  = dec_imm_src;
               if (dec_is_branch) begin
                  pc_en  = 1'b1;
                  pc_sel = dec_is_beq ? EQ : ~EQ;
               end
            end
            ST_WRITEBACK: begin
               ALUctrl  = dec_alu_ctrl;
               ALUsrc   = dec_alu_src;
               ImmSrc   = dec_imm_src;
               RegWrite = (dec_rd != '0);   // x0 is hard-wired zero
               pc_en    = 1'b1;
            end
            ST_TRAP: begin
               trap = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. A behavioural model classifies each
// instruction word from its RV32I fields and predicts the cycle-by-cycle
// control outputs and the retired count.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] instr = '0;
   logic        EQ = 1'b0;
   logic [4:0]  rs1, rs2, rd;
   logic        RegWrite, ALUsrc, ImmSrc, pc_en, pc_sel, trap;
   logic [2:0]  ALUctrl;
   logic [31:0] retired;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] exp_ret;
   logic [31:0] exp_q[$];

   multicycle_ctrl #(.A_WIDTH(5), .D_WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .EQ          (EQ),
      .rs1         (rs1),
      .rs2         (rs2),
      .rd          (rd),
      .RegWrite    (RegWrite),
      .ALUsrc      (ALUsrc),
      .ALUctrl     (ALUctrl),
      .ImmSrc      (ImmSrc),
      .pc_en       (pc_en),
      .pc_sel      (pc_sel),
      .trap        (trap),
      .retired     (retired)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // Classifies a word by its mnemonic and gives the controls it must produce.
   function automatic void model(input logic [31:0] w, output bit legal, output bit br,
                                 output bit beq, output logic [2:0] alu,
                                 output bit src, output bit imm);
      logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
      op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
      legal = 0; br = 0; beq = 0; alu = 3'd0; src = 0; imm = 0;
      if (op == 7'h13 && f3 == 3'd0) begin legal = 1; src = 1; end                      // ADDI
      else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0) begin legal = 1; end             // ADD
      else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin legal = 1; alu = 3'd1; end // SUB
      else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7) begin legal = 1; alu = 3'd2; end // AND
      else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd6) begin legal = 1; alu = 3'd3; end // OR
      else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin                           // BEQ/BNE
         legal = 1; br = 1; beq = (f3 == 3'd0); alu = 3'd1; imm = 1;
      end
   endfunction

   function automatic logic [31:0] rand_legal();
      logic [4:0] a, b, d; logic [11:0] i12; logic [6:0] hi;
      a = 5'($urandom); b = 5'($urandom); d = 5'($urandom);
      i12 = 12'($urandom); hi = 7'($urandom);
      case ($urandom_range(0, 6))
         0:       return {i12, a, 3'b000, d, 7'b0010011};
         1:       return {7'b0000000, b, a, 3'b000, d, 7'b0110011};
         2:       return {7'b0100000, b, a, 3'b000, d, 7'b0110011};
         3:       return {7'b0000000, b, a, 3'b111, d, 7'b0110011};
         4:       return {7'b0000000, b, a, 3'b110, d, 7'b0110011};
         5:       return {hi, b, a, 3'b000, d, 7'b1100011};
         default: return {hi, b, a, 3'b001, d, 7'b1100011};
      endcase
   endfunction

   // ---------------- driver: reset ----------------
   task automatic apply_reset(input string tag);
      rst = 1'b1; instr_valid = 1'b0; EQ = 1'b0;
      tick(); tick();
      tests_run++; if (instr_ready !== 1'b0) begin tests_failed++; $display("FAIL %s in-rst instr_ready got %0b exp 0", tag, instr_ready); end
      tests_run++; if (trap !== 1'b0) begin tests_failed++; $display("FAIL %s in-rst trap got %0b exp 0", tag, trap); end
      tests_run++; if (retired !== 32'd0) begin tests_failed++; $display("FAIL %s in-rst retired got %0h exp 0", tag, retired); end
      tests_run++; if ({pc_en, RegWrite} !== 2'b00) begin tests_failed++; $display("FAIL %s in-rst strobes got %b exp 00", tag, {pc_en, RegWrite}); end
      rst = 1'b0;
      #1;
      tests_run++; if (instr_ready !== 1'b1) begin tests_failed++; $display("FAIL %s post-rst instr_ready got %0b exp 1", tag, instr_ready); end
      tests_run++; if (trap !== 1'b0) begin tests_failed++; $display("FAIL %s post-rst trap got %0b exp 0", tag, trap); end
      tests_run++; if (retired !== 32'd0) begin tests_failed++; $display("FAIL %s post-rst retired got %0h exp 0", tag, retired); end
      tests_run++; if ({rs1, rs2, rd} !== 15'd0) begin tests_failed++; $display("FAIL %s post-rst regs got %h exp 0", tag, {rs1, rs2, rd}); end
      exp_ret = 32'd0;
      exp_q.delete();
   endtask

   // ---------------- driver: one instruction, entered in a FETCH cycle ------
   task automatic do_instr(input string tag, input logic [31:0] w, input bit eq_v, input bit hold);
      bit legal, br, beq, src, imm; logic [2:0] alu; logic [31:0] sb;
      model(w, legal, br, beq, alu, src, imm);
      instr = w; instr_valid = 1'b1; EQ = eq_v;
      #1;
      tests_run++; if (instr_ready !== 1'b1) begin tests_failed++; $display("FAIL %s fetch instr_ready got %0b exp 1", tag, instr_ready); end
      tick();  // DECODE
      exp_q.push_back(w);
      if (!hold) instr_valid = 1'b0;
      instr = $urandom;  // word offered outside FETCH must have no effect
      #1;
      tests_run++; if (instr_ready !== 1'b0) begin tests_failed++; $display("FAIL %s decode instr_ready got %0b exp 0", tag, instr_ready); end
      tests_run++; if ({rs1, rs2, rd} !== {w[19:15], w[24:20], w[11:7]}) begin tests_failed++; $display("FAIL %s decode regs got %h exp %h", tag, {rs1, rs2, rd}, {w[19:15], w[24:20], w[11:7]}); end
      tests_run++; if ({pc_en, RegWrite, trap} !== 3'b000) begin tests_failed++; $display("FAIL %s decode strobes got %b exp 000", tag, {pc_en, RegWrite, trap}); end
      tick();  // EXECUTE or TRAP
      if (!legal) begin
         tests_run++; if (trap !== 1'b1) begin tests_failed++; $display("FAIL %s trap got %0b exp 1", tag, trap); end
         tests_run++; if ({instr_ready, pc_en, RegWrite} !== 3'b000) begin tests_failed++; $display("FAIL %s trap ready/strobes got %b exp 000", tag, {instr_ready, pc_en, RegWrite}); end
         void'(exp_q.pop_front());
         return;
      end
      tests_run++; if ({ALUctrl, ALUsrc, ImmSrc} !== {alu, src, imm}) begin tests_failed++; $display("FAIL %s exec ctrl got %b exp %b", tag, {ALUctrl, ALUsrc, ImmSrc}, {alu, src, imm}); end
      tests_run++; if (RegWrite !== 1'b0) begin tests_failed++; $display("FAIL %s exec RegWrite got %0b exp 0", tag, RegWrite); end
      if (br) begin
         tests_run++; if (pc_en !== 1'b1) begin tests_failed++; $display("FAIL %s branch pc_en got %0b exp 1", tag, pc_en); end
         tests_run++; if (pc_sel !== (beq ? eq_v : !eq_v)) begin tests_failed++; $display("FAIL %s branch pc_sel got %0b exp %0b", tag, pc_sel, (beq ? eq_v : !eq_v)); end
         sb = exp_q.pop_front();
         exp_ret = exp_ret + 32'd1;
         tick();  // FETCH
      end else begin
         tests_run++; if (pc_en !== 1'b0) begin tests_failed++; $display("FAIL %s exec pc_en got %0b exp 0", tag, pc_en); end
         tick();  // WRITEBACK
         sb = exp_q.pop_front();
         tests_run++; if (RegWrite !== (sb[11:7] != 5'd0)) begin tests_failed++; $display("FAIL %s wb RegWrite got %0b exp %0b", tag, RegWrite, (sb[11:7] != 5'd0)); end
         tests_run++; if (rd !== sb[11:7]) begin tests_failed++; $display("FAIL %s wb rd got %0d exp %0d", tag, rd, sb[11:7]); end
         tests_run++; if ({pc_en, pc_sel} !== 2'b10) begin tests_failed++; $display("FAIL %s wb pc got %b exp 10", tag, {pc_en, pc_sel}); end
         tests_run++; if ({ALUctrl, ALUsrc, ImmSrc} !== {alu, src, imm}) begin tests_failed++; $display("FAIL %s wb ctrl got %b exp %b", tag, {ALUctrl, ALUsrc, ImmSrc}, {alu, src, imm}); end
         tests_run++; if (retired !== exp_ret) begin tests_failed++; $display("FAIL %s wb retired got %0h exp %0h", tag, retired, exp_ret); end
         exp_ret = exp_ret + 32'd1;
         tick();  // FETCH
      end
      tests_run++; if (instr_ready !== 1'b1) begin tests_failed++; $display("FAIL %s next-fetch instr_ready got %0b exp 1", tag, instr_ready); end
      tests_run++; if (retired !== exp_ret) begin tests_failed++; $display("FAIL %s retired got %0h exp %0h", tag, retired, exp_ret); end
      tests_run++; if ({pc_en, RegWrite} !== 2'b00) begin tests_failed++; $display("FAIL %s next-fetch strobes got %b exp 00", tag, {pc_en, RegWrite}); end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      instr_valid = 1'b1;
      apply_reset("reset");
   endtask

   task automatic test_addi();
      apply_reset("addi_rst");
      do_instr("addi_x5_7", 32'h00700293, 1'b0, 1'b0);
   endtask

   task automatic test_sub_and();
      apply_reset("subend_rst");
      do_instr("sub_x3", 32'h402081B3, 1'b0, 1'b0);
      do_instr("and_x0", 32'h0020F033, 1'b0, 1'b0);
      tests_run++; if (retired !== 32'd2) begin tests_failed++; $display("FAIL sub_and retired got %0d exp 2", retired); end
   endtask

   task automatic test_branch();
      do_instr("bne_eq0", 32'h00209463, 1'b0, 1'b0);
      do_instr("bne_eq1", 32'h00209463, 1'b1, 1'b0);
      do_instr("beq_eq1", 32'h00208463, 1'b1, 1'b0);
      do_instr("beq_eq0", 32'h00208463, 1'b0, 1'b0);
   endtask

   task automatic test_illegal();
      logic [31:0] bad[5];
      apply_reset("illegal_rst");
      do_instr("pre_addi", 32'h00100093, 1'b0, 1'b0);
      do_instr("illegal_ff", 32'hFFFFFFFF, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick();
         tests_run++; if ({instr_ready, trap} !== 2'b01) begin tests_failed++; $display("FAIL trap_hold cyc %0d ready/trap got %b exp 01", i, {instr_ready, trap}); end
      end
      apply_reset("trap_clear");
      bad[0] = {7'b0100000, 5'd2, 5'd1, 3'b111, 5'd3, 7'b0110011};  // funct7 SUB with AND funct3
      bad[1] = {12'd4, 5'd1, 3'b001, 5'd3, 7'b0010011};             // SLLI
      bad[2] = {7'd0, 5'd2, 5'd1, 3'b100, 5'd8, 7'b1100011};        // BLT
      bad[3] = {12'd0, 5'd1, 3'b010, 5'd3, 7'b0000011};             // LW
      bad[4] = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};  // MUL
      for (int i = 0; i < 5; i++) begin
         do_instr($sformatf("illegal_%0d", i), bad[i], 1'b0, 1'b0);
         apply_reset($sformatf("illegal_%0d_rst", i));
      end
   endtask

   task automatic test_rst_mid();
      apply_reset("mid_rst_pre");
      instr = 32'h002081B3; instr_valid = 1'b1;  // ADD x3,x1,x2
      tick();  // DECODE
      instr_valid = 1'b0;
      tick();  // EXECUTE
      rst = 1'b1;
      #1;
      tests_run++; if ({pc_en, RegWrite, instr_ready} !== 3'b000) begin tests_failed++; $display("FAIL rst_mid exec-edge strobes got %b exp 000", {pc_en, RegWrite, instr_ready}); end
      tick();
      tests_run++; if ({pc_en, RegWrite} !== 2'b00) begin tests_failed++; $display("FAIL rst_mid next strobes got %b exp 00", {pc_en, RegWrite}); end
      rst = 1'b0;
      #1;
      tests_run++; if (instr_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid release instr_ready got %0b exp 1", instr_ready); end
      tests_run++; if (retired !== 32'd0) begin tests_failed++; $display("FAIL rst_mid retired got %0h exp 0", retired); end
      tests_run++; if ({pc_en, RegWrite} !== 2'b00) begin tests_failed++; $display("FAIL rst_mid release strobes got %b exp 00", {pc_en, RegWrite}); end
      exp_ret = 32'd0;
   endtask

   task automatic test_wrap();
      apply_reset("wrap_rst");
      force dut.retired_q = 32'hFFFFFFFF;
      tick();
      release dut.retired_q;
      #1;
      tests_run++; if (retired !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL wrap preload got %0h exp ffffffff", retired); end
      exp_ret = 32'hFFFFFFFF;
      do_instr("wrap_addi", 32'h00700293, 1'b0, 1'b0);
      tests_run++; if (retired !== 32'd0) begin tests_failed++; $display("FAIL wrap result got %0h exp 0", retired); end
   endtask

   task automatic test_random();
      apply_reset("rand_rst");
      for (int i = 0; i < 40; i++)
         do_instr($sformatf("rand_%0d", i), rand_legal(), 1'($urandom), 1'b0);
   endtask

   task automatic test_back_to_back();
      apply_reset("b2b_rst");
      for (int i = 0; i < 12; i++)
         do_instr($sformatf("b2b_%0d", i), rand_legal(), 1'($urandom), 1'b1);
      instr_valid = 1'b0;
      tests_run++; if (retired !== 32'd12) begin tests_failed++; $display("FAIL b2b retired got %0d exp 12", retired); end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_addi();
      test_sub_and();
      test_branch();
      test_illegal();
      test_rst_mid();
      test_wrap();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
